ysyx_24090012_ifu: RTL and testbench

Instruction fetch unit for the multi-cycle core; sits directly upstream of the IDU. Holds the architectural PC, issues one AXI-lite-style read per instruction, and presents the fetched word with its PC to the IDU over a valid/ready handshake. It then waits for the commit-time next PC before fetching again. Fetch faults (misaligned PC, bus error, response timeout) are reported alongside the instruction rather than stalling the core.

---
 rtl/ysyx_24090012_pkg.sv | 28 ++
 rtl/ysyx_24090012_ifu.sv | 177 +++++++++++++++++
 tb/tb_ysyx_24090012_ifu.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24090012_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24090012_pkg
// Purpose  : Shared definitions for the instruction fetch unit: FSM state
//            encoding, fetch fault codes and the default reset PC.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_24090012_pkg;

  // Fetch FSM states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    S_REQ       = 2'd0,
    S_WAIT_RESP = 2'd1,
    S_HOLD      = 2'd2,
    S_WAIT_NPC  = 2'd3
  } ifu_state_e;

  // Fault codes reported alongside the instruction.
  localparam logic [1:0] C_FAULT_NONE     = 2'd0;
  localparam logic [1:0] C_FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] C_FAULT_ACCESS   = 2'd2;
  localparam logic [1:0] C_FAULT_TIMEOUT  = 2'd3;

  localparam logic [31:0] C_RESET_PC_DEFAULT = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/ysyx_24090012_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24090012_ifu
// Purpose  : Instruction fetch unit. Holds the PC, issues one read per
//            instruction, hands the word (plus PC and fault code) to the IDU
//            over valid/ready, then waits for the commit-time next PC.
// Ports    : clock/reset        - clock, synchronous active-low reset
//            mem_ar*            - read request (address = PC)
//            mem_r*             - read response (data, resp, handshake)
//            ifu_valid/ready    - instruction handshake towards the IDU
//            inst/ifu_to_idu_pc - fetched word and its PC
//            ifu_fault          - 0 none, 1 misaligned, 2 access, 3 timeout
//            npc_valid/npc      - next PC from the commit stage
//            state_out          - debug view of the FSM state
//            perf_fetch_cnt     - number of IDU handshakes
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24090012_ifu
  import ysyx_24090012_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        ifu_valid,
  input  logic        ifu_ready,
  output logic [31:0] inst,
  output logic [31:0] ifu_to_idu_pc,
  output logic [1:0]  ifu_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic [2:0]  state_out,
  output logic [31:0] perf_fetch_cnt
);

  // Counter value at which the current wait cycle is the last one allowed.
  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 32'd1);

  ifu_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_npc_pc;
  logic [31:0] r_perf;
  logic [1:0]  r_fault;
  logic [7:0]  r_cnt;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_ifu_valid;
  logic        r_npc_pend;
  logic        r_drain;

  logic        w_drain_nxt;
  logic [31:0] w_npc_sel;

  // Drain flag value after this cycle: a response seen while draining is
  // the stale one from the timed-out request and clears it.
  assign w_drain_nxt = r_drain && !mem_rvalid;
  // A fresh pulse takes priority over an older pending value.
  assign w_npc_sel   = npc_valid ? npc : r_npc_pc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_npc_pc    <= '0;
      r_perf      <= '0;
      r_fault     <= C_FAULT_NONE;
      r_cnt       <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_ifu_valid <= 1'b0;
      r_npc_pend  <= 1'b0;
      r_drain     <= 1'b0;
    end else begin
      // The commit stage may run ahead of us; remember its npc.
      if (npc_valid && r_state != S_WAIT_NPC) begin
        r_npc_pend <= 1'b1;
        r_npc_pc   <= npc;
      end
      if (r_drain && mem_rvalid) begin
        r_drain <= 1'b0;
      end

      case (r_state)
        S_REQ: begin
          r_rready <= w_drain_nxt;
          if (r_arvalid && mem_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_WAIT_RESP;
          end else begin
            // Hold off the request until any stale response is drained.
            r_arvalid <= !w_drain_nxt;
          end
        end

        S_WAIT_RESP: begin
          if (mem_rvalid) begin
            r_rready    <= 1'b0;
            r_ifu_valid <= 1'b1;
            r_state     <= S_HOLD;
            if (mem_rresp != 2'b00) begin
              r_inst  <= '0;
              r_fault <= C_FAULT_ACCESS;
            end else begin
              r_inst  <= mem_rdata;
              r_fault <= C_FAULT_NONE;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            // Give up; the response may still arrive later and must be
            // swallowed, so keep rready high via the drain flag.
            r_cnt       <= r_cnt + 8'd1;
            r_inst      <= '0;
            r_fault     <= C_FAULT_TIMEOUT;
            r_drain     <= 1'b1;
            r_rready    <= 1'b1;
            r_ifu_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_HOLD: begin
          r_rready <= w_drain_nxt;
          if (ifu_ready) begin
            r_ifu_valid <= 1'b0;
            r_perf      <= r_perf + 32'd1;
            r_state     <= S_WAIT_NPC;
          end
        end

        S_WAIT_NPC: begin
          r_rready <= w_drain_nxt;
          if (npc_valid || r_npc_pend) begin
            r_pc       <= w_npc_sel;
            r_npc_pend <= 1'b0;
            if (w_npc_sel[1:0] != 2'b00) begin
              // Misaligned target: report it without touching the bus.
              r_inst      <= '0;
              r_fault     <= C_FAULT_MISALIGN;
              r_ifu_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else begin
              r_arvalid <= !w_drain_nxt;
              r_state   <= S_REQ;
            end
          end
        end

        default: r_state <= S_REQ;
      endcase
    end
  end

  assign mem_arvalid    = r_arvalid;
  assign mem_araddr     = r_pc;
  assign mem_rready     = r_rready;
  assign ifu_valid      = r_ifu_valid;
  assign inst           = r_inst;
  assign ifu_to_idu_pc  = r_pc;
  assign ifu_fault      = r_fault;
  assign state_out      = {1'b0, r_state};
  assign perf_fetch_cnt = r_perf;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090012_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24090012_ifu
// Purpose  : Self-checking bench for the fetch unit. A memory responder and
//            an IDU/commit driver generate random traffic and push expected
//            instructions into a scoreboard; a monitor pops and compares on
//            every IDU handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090012_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = '0;
  logic        mem_rready;
  logic        ifu_valid;
  logic        ifu_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] ifu_to_idu_pc;
  logic [1:0]  ifu_fault;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = '0;
  logic [2:0]  state_out;
  logic [31:0] perf_fetch_cnt;

  logic [31:0] pc_q[$];   // addresses the next bus request must carry
  exp_t        sb_q[$];   // instructions the IDU must receive, in order
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_total = 0;

  ysyx_24090012_ifu #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(mem_rready),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .inst(inst),
    .ifu_to_idu_pc(ifu_to_idu_pc), .ifu_fault(ifu_fault),
    .npc_valid(npc_valid), .npc(npc),
    .state_out(state_out), .perf_fetch_cnt(perf_fetch_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_arvalid", 96'(mem_arvalid), 96'd0);
    check("rst_araddr", 96'(mem_araddr), 96'(RST_PC));
    check("rst_rready", 96'(mem_rready), 96'd0);
    check("rst_ifu_valid", 96'(ifu_valid), 96'd0);
    check("rst_inst", 96'(inst), 96'd0);
    check("rst_fault", 96'(ifu_fault), 96'd0);
    check("rst_perf", 96'(perf_fetch_cnt), 96'd0);
    check("rst_state", 96'(state_out), 96'd0);
  endtask

  // Memory contents: first reset word fixed, the rest a simple hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0010_0093;
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Next PC: mostly sequential, sometimes a jump, sometimes misaligned.
  function automatic logic [31:0] pick(input logic [31:0] c);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return {c[31:2] + 30'd1, 2'($urandom_range(1, 3))};
    if (r <= 6) return {c[31:2], 2'b00} + 32'd4;
    return RST_PC + {22'd0, 8'($urandom), 2'b00};
  endfunction

  task automatic deliver(input logic [31:0] v);
    npc_valid = 1'b1;
    npc       = v;
    if (v[1:0] != 2'b00) sb_q.push_back('{pc: v, inst: 32'h0, fault: 2'd1});
    else                 pc_q.push_back(v);
  endtask

  // Memory responder: accepts one request at a time, answers after a random
  // number of idle cycles (long enough ones exceed the timeout and arrive late).
  initial begin : mem_model
    int          ar_wait;
    int          lat;
    int          phase;
    bit          first;
    bit          err;
    logic [31:0] word;
    logic [31:0] a;
    ar_wait = 0; lat = 0; phase = 0; first = 1'b1; err = 1'b0; word = '0; a = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mem_arready = 1'b0; mem_rvalid = 1'b0;
        phase = 0; ar_wait = 0; first = 1'b1;
        continue;
      end
      if (phase == 2) begin
        mem_rvalid = 1'b0;
        phase = 0;
      end
      if (!mem_rvalid) begin
        mem_rdata = $urandom;
        mem_rresp = 2'($urandom);
      end
      mem_arready = 1'b0;
      if (phase == 0) begin
        if (mem_arvalid) begin
          if (ar_wait > 0) begin
            ar_wait--;
          end else begin
            mem_arready = 1'b1;
            a = mem_araddr;
            if (pc_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL ar_unexpected: got request %0h expected none", a);
            end else begin
              check("araddr", 96'(a), 96'(pc_q.pop_front()));
            end
            lat  = first ? 0 : int'($urandom_range(0, 8));
            err  = first ? 1'b0 : ($urandom_range(0, 4) == 0);
            word = mem_word(a);
            if (lat >= TMO)  sb_q.push_back('{pc: a, inst: 32'h0, fault: 2'd3});
            else if (err)    sb_q.push_back('{pc: a, inst: 32'h0, fault: 2'd2});
            else             sb_q.push_back('{pc: a, inst: word, fault: 2'd0});
            first   = 1'b0;
            ar_wait = int'($urandom_range(0, 2));
            phase   = 1;
          end
        end
      end else begin
        check("no_ar_while_busy", 96'(mem_arvalid), 96'd0);
        if (lat > 0) begin
          lat--;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata  = err ? 32'hFFFF_FFFF : word;
          mem_rresp  = err ? 2'b10 : 2'b00;
          if (mem_rready) phase = 2;
        end
      end
    end
  end

  // IDU / commit driver: random backpressure, next PC sent either in the
  // handshake cycle (possibly after a stray earlier pulse) or a few cycles later.
  initial begin : idu_model
    int          bp;
    int          delay;
    int          phase;
    bit          first;
    bit          early;
    logic [31:0] cur;
    logic [31:0] nxt;
    bp = 5; delay = 0; phase = 0; first = 1'b1; early = 1'b1; cur = RST_PC; nxt = '0;
    forever begin
      @(negedge clock);
      npc_valid = 1'b0;
      npc       = $urandom;
      if (!reset) begin
        ifu_ready = 1'b0; bp = 5; phase = 0; first = 1'b1; early = 1'b1; cur = RST_PC;
        continue;
      end
      if (phase == 0) begin
        if (ifu_valid) begin
          if (bp > 0) begin
            ifu_ready = 1'b0;
            bp--;
          end else begin
            ifu_ready = ($urandom_range(0, 3) != 0);
          end
          if (ifu_ready) begin
            nxt   = first ? cur + 32'd4 : pick(cur);
            first = 1'b0;
            if (early) begin
              deliver(nxt);
              cur   = nxt;
              early = ($urandom_range(0, 1) == 1);
            end else begin
              delay = int'($urandom_range(0, 3));
              phase = 1;
            end
          end else if (early && $urandom_range(0, 3) == 0) begin
            // Stray pulse; the one in the handshake cycle must overwrite it.
            npc_valid = 1'b1;
          end
        end else begin
          ifu_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        ifu_ready = 1'($urandom_range(0, 1));
        if (delay > 0) begin
          delay--;
        end else begin
          deliver(nxt);
          cur   = nxt;
          early = ($urandom_range(0, 1) == 1);
          phase = 0;
        end
      end
    end
  end

  // Monitor: compares every IDU handshake against the scoreboard, checks
  // output stability under backpressure and the handshake counter.
  initial begin : monitor
    logic        pv;
    logic        phs;
    logic        perf_due;
    logic [31:0] ppc;
    logic [31:0] pinst;
    logic [1:0]  pf;
    logic [31:0] hs_model;
    exp_t        e;
    pv = 1'b0; phs = 1'b0; perf_due = 1'b0; ppc = '0; pinst = '0; pf = '0; hs_model = '0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        pv = 1'b0; phs = 1'b0; perf_due = 1'b0; hs_model = '0;
        continue;
      end
      if (perf_due) check("perf_fetch_cnt", 96'(perf_fetch_cnt), 96'(hs_model));
      perf_due = 1'b0;
      if (pv && !phs)
        check("hold_stable", 96'({ifu_valid, ifu_to_idu_pc, inst, ifu_fault}),
              96'({1'b1, ppc, pinst, pf}));
      if (ifu_valid && ifu_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ifu_unexpected: got pc %0h inst %0h expected none", ifu_to_idu_pc, inst);
        end else begin
          e = sb_q.pop_front();
          check("ifu_pc", 96'(ifu_to_idu_pc), 96'(e.pc));
          check("ifu_inst", 96'(inst), 96'(e.inst));
          check("ifu_fault", 96'(ifu_fault), 96'(e.fault));
        end
        hs_model = hs_model + 32'd1;
        hs_total++;
        perf_due = 1'b1;
      end
      pv    = ifu_valid;
      phs   = ifu_valid && ifu_ready;
      ppc   = ifu_to_idu_pc;
      pinst = inst;
      pf    = ifu_fault;
    end
  end

  task automatic wait_hs(input int target);
    int cyc;
    cyc = 0;
    while (hs_total < target && cyc < 20000) begin
      @(posedge clock);
      cyc++;
    end
    n_cmp++;
    if (hs_total < target) begin
      n_bad++;
      $display("FAIL progress: got %0d handshakes expected %0d", hs_total, target);
    end
  endtask

  initial begin : main
    pc_q.push_back(RST_PC);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    // First non-reset edge has passed: request goes out immediately.
    check("first_arvalid", 96'(mem_arvalid), 96'd1);
    check("first_araddr", 96'(mem_araddr), 96'(RST_PC));
    @(negedge clock);
    check("zero_wait_valid_low", 96'(ifu_valid), 96'd0);
    @(negedge clock);
    check("zero_wait_valid_rise", 96'(ifu_valid), 96'd1);

    wait_hs(150);

    // Reset in the middle of traffic.
    @(posedge clock);
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset();
    pc_q.delete();
    sb_q.delete();
    pc_q.push_back(RST_PC);
    @(posedge clock);
    #2 reset = 1'b1;

    wait_hs(hs_total + 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
